// File: rtl/lat_monitor.sv
// rtl/lat_monitor.sv - cycle-based checker that models a set/reset latch and flags output mismatches
module lat_monitor #(
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pre,
  input  logic             clr,
  input  logic             d,
  input  logic             q,
  input  logic             err_clr,
  output logic             exp_q,
  output logic             exp_valid,
  output logic             mismatch,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_UNK    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  localparam logic             POL       = ACTIVE_LOW;
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [2:0]       prev_cpe;
  logic             prev_d;
  logic [3:0]       cnt;

  logic             c;
  logic             p;
  logic             e;
  logic [2:0]       cpe;
  logic             change;
  logic             do_cmp;
  logic             miss;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W-1:0] err_next;

  assign state = state_q;

  // Normalise polarity, detect control/data changes and decide whether this edge is compared
  always_comb begin
    c        = clr ^ POL;
    p        = pre ^ POL;
    e        = en ^ POL;
    cpe      = {c, p, e};
    change   = (cpe != prev_cpe) || (e && !c && !p && (d != prev_d));
    do_cmp   = (state_q != ST_UNK) && exp_valid && (cnt == 4'd0) && !change;
    miss     = do_cmp && (q != exp_q);
    err_base = err_clr ? '0 : err_cnt;
    err_next = (miss && (err_base != ERR_MAX)) ? (err_base + ERR_ONE) : err_base;
  end

  // Reference latch model: clear beats preset beats enable, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      prev_cpe  <= 3'b000;
      prev_d    <= 1'b0;
    end else begin
      if (c) begin
        exp_q <= 1'b0;
      end else if (p) begin
        exp_q <= 1'b1;
      end else if (e) begin
        exp_q <= d;
      end
      if (c || p || e) begin
        exp_valid <= 1'b1;
      end
      prev_cpe <= cpe;
      prev_d   <= d;
    end
  end

  // Grace counter: reload on every change, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (change) begin
      cnt <= SETTLE_LD;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Monitor phase: unknown until first defining event, then alternate between settling and checking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_UNK;
    end else begin
      case (state_q)
        ST_UNK: begin
          if (c || p || e) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if ((cnt == 4'd0) && !change) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (change) begin
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_UNK;
      endcase
    end
  end

  // Error reporting: one-cycle pulse, sticky flag and saturating count; err_clr clears before counting
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
      fail     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      mismatch <= miss;
      fail     <= (fail && !err_clr) || miss;
      err_cnt  <= err_next;
    end
  end

endmodule

// File: tb/tb_lat_monitor.sv
// tb/tb_lat_monitor.sv - directed self-checking bench for lat_monitor
`timescale 1ns/1ps
module tb_lat_monitor;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] en_v = 3'b000, pre_v = 3'b000, clr_v = 3'b000, d_v = 3'b000, q_v = 3'b000, ec_v = 3'b000;

  logic       eq0, ev0, mm0, fl0;
  logic [7:0] ec0;
  logic [1:0] st0;
  logic       eq1, ev1, mm1, fl1;
  logic [7:0] ec1;
  logic [1:0] st1;
  logic       eq2, ev2, mm2, fl2;
  logic [1:0] ec2;
  logic [1:0] st2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lat_monitor #(.ACTIVE_LOW(1'b0), .SETTLE(1), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .pre(pre_v[0]), .clr(clr_v[0]), .d(d_v[0]), .q(q_v[0]),
    .err_clr(ec_v[0]), .exp_q(eq0), .exp_valid(ev0), .mismatch(mm0), .fail(fl0), .err_cnt(ec0), .state(st0)
  );

  lat_monitor #(.ACTIVE_LOW(1'b1), .SETTLE(1), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .pre(pre_v[1]), .clr(clr_v[1]), .d(d_v[1]), .q(q_v[1]),
    .err_clr(ec_v[1]), .exp_q(eq1), .exp_valid(ev1), .mismatch(mm1), .fail(fl1), .err_cnt(ec1), .state(st1)
  );

  lat_monitor #(.ACTIVE_LOW(1'b0), .SETTLE(0), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .pre(pre_v[2]), .clr(clr_v[2]), .d(d_v[2]), .q(q_v[2]),
    .err_clr(ec_v[2]), .exp_q(eq2), .exp_valid(ev2), .mismatch(mm2), .fail(fl2), .err_cnt(ec2), .state(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_v = 3'b111;
    en_v[1] = 1'b1; pre_v[1] = 1'b1; clr_v[1] = 1'b1;
    q_v[2] = 1'b1;
    tick(); tick();
    n_cmp++; if (eq0 !== 1'b0) begin n_bad++; $display("FAIL rst_exp_q got=%0d exp=0", eq0); end
    n_cmp++; if (ev0 !== 1'b0) begin n_bad++; $display("FAIL rst_exp_valid got=%0d exp=0", ev0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL rst_mismatch got=%0d exp=0", mm0); end
    n_cmp++; if (fl0 !== 1'b0) begin n_bad++; $display("FAIL rst_fail got=%0d exp=0", fl0); end
    n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL rst_err_cnt got=%0d exp=0", ec0); end
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", st0); end
    n_cmp++; if (st1 !== 2'd0) begin n_bad++; $display("FAIL rst_state_al got=%0d exp=0", st1); end
    rst_v = 3'b000;
    tick(); tick();
    n_cmp++; if (st2 !== 2'd0) begin n_bad++; $display("FAIL unk_state got=%0d exp=0", st2); end
    n_cmp++; if (mm2 !== 1'b0) begin n_bad++; $display("FAIL unk_no_cmp got=%0d exp=0", mm2); end
    n_cmp++; if (ev2 !== 1'b0) begin n_bad++; $display("FAIL unk_exp_valid got=%0d exp=0", ev2); end
    n_cmp++; if (st1 !== 2'd0) begin n_bad++; $display("FAIL al_idle_state got=%0d exp=0", st1); end
  endtask

  task automatic test_clr_settle();
    q_v[0] = 1'b0; clr_v[0] = 1'b1;
    tick();
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL clr_state1 got=%0d exp=1", st0); end
    n_cmp++; if (eq0 !== 1'b0) begin n_bad++; $display("FAIL clr_exp_q got=%0d exp=0", eq0); end
    n_cmp++; if (ev0 !== 1'b1) begin n_bad++; $display("FAIL clr_exp_valid got=%0d exp=1", ev0); end
    clr_v[0] = 1'b0;
    tick();
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL clr_state2 got=%0d exp=1", st0); end
    tick();
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL clr_state3 got=%0d exp=1", st0); end
    tick();
    n_cmp++; if (st0 !== 2'd2) begin n_bad++; $display("FAIL clr_state4 got=%0d exp=2", st0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL clr_mismatch got=%0d exp=0", mm0); end
    n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL clr_err_cnt got=%0d exp=0", ec0); end
  endtask

  task automatic test_priority();
    pre_v[0] = 1'b1; en_v[0] = 1'b1; d_v[0] = 1'b0; q_v[0] = 1'b1;
    tick();
    n_cmp++; if (eq0 !== 1'b1) begin n_bad++; $display("FAIL pri_exp_q got=%0d exp=1", eq0); end
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL pri_state_a got=%0d exp=1", st0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL pri_mm_a got=%0d exp=0", mm0); end
    tick();
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL pri_state_b got=%0d exp=1", st0); end
    tick();
    n_cmp++; if (st0 !== 2'd2) begin n_bad++; $display("FAIL pri_state_c got=%0d exp=2", st0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL pri_mm_c got=%0d exp=0", mm0); end
    tick();
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL pri_mm_d got=%0d exp=0", mm0); end
    n_cmp++; if (fl0 !== 1'b0) begin n_bad++; $display("FAIL pri_fail got=%0d exp=0", fl0); end
  endtask

  task automatic test_mismatch_err_clr();
    q_v[0] = 1'b0;
    tick();
    n_cmp++; if (mm0 !== 1'b1) begin n_bad++; $display("FAIL mm_pulse_e got=%0d exp=1", mm0); end
    n_cmp++; if (fl0 !== 1'b1) begin n_bad++; $display("FAIL mm_fail_e got=%0d exp=1", fl0); end
    n_cmp++; if (ec0 !== 8'd1) begin n_bad++; $display("FAIL mm_cnt_e got=%0d exp=1", ec0); end
    tick();
    n_cmp++; if (ec0 !== 8'd2) begin n_bad++; $display("FAIL mm_cnt_f got=%0d exp=2", ec0); end
    ec_v[0] = 1'b1;
    tick();
    n_cmp++; if (ec0 !== 8'd1) begin n_bad++; $display("FAIL clrcnt_cnt got=%0d exp=1", ec0); end
    n_cmp++; if (fl0 !== 1'b1) begin n_bad++; $display("FAIL clrcnt_fail got=%0d exp=1", fl0); end
    n_cmp++; if (mm0 !== 1'b1) begin n_bad++; $display("FAIL clrcnt_mm got=%0d exp=1", mm0); end
    q_v[0] = 1'b1;
    tick();
    n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL clr_only_cnt got=%0d exp=0", ec0); end
    n_cmp++; if (fl0 !== 1'b0) begin n_bad++; $display("FAIL clr_only_fail got=%0d exp=0", fl0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL clr_only_mm got=%0d exp=0", mm0); end
    ec_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_settle();
    clr_v[0] = 1'b1; q_v[0] = 1'b1;
    tick();
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL mid_state got=%0d exp=1", st0); end
    n_cmp++; if (eq0 !== 1'b0) begin n_bad++; $display("FAIL mid_exp_q got=%0d exp=0", eq0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL mid_mm got=%0d exp=0", mm0); end
    q_v[0] = 1'b0;
    tick();
    n_cmp++; if (st0 !== 2'd1) begin n_bad++; $display("FAIL mid_state2 got=%0d exp=1", st0); end
    rst_v[0] = 1'b1; q_v[0] = 1'b1; ec_v[0] = 1'b1;
    tick();
    n_cmp++; if ({eq0, ev0, mm0, fl0} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_flags got=%b exp=0000", {eq0, ev0, mm0, fl0}); end
    n_cmp++; if (ec0 !== 8'd0) begin n_bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", ec0); end
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL mid_rst_state got=%0d exp=0", st0); end
    rst_v[0] = 1'b0; ec_v[0] = 1'b0;
    en_v[0] = 1'b0; pre_v[0] = 1'b0; clr_v[0] = 1'b0; d_v[0] = 1'b0;
    tick();
    n_cmp++; if (st0 !== 2'd0) begin n_bad++; $display("FAIL post_rst_state got=%0d exp=0", st0); end
    n_cmp++; if (mm0 !== 1'b0) begin n_bad++; $display("FAIL post_rst_mm got=%0d exp=0", mm0); end
  endtask

  task automatic test_active_low();
    q_v[1] = 1'b0; clr_v[1] = 1'b0;
    tick();
    n_cmp++; if (st1 !== 2'd1) begin n_bad++; $display("FAIL al_state1 got=%0d exp=1", st1); end
    n_cmp++; if (eq1 !== 1'b0) begin n_bad++; $display("FAIL al_exp_q1 got=%0d exp=0", eq1); end
    n_cmp++; if (ev1 !== 1'b1) begin n_bad++; $display("FAIL al_exp_valid got=%0d exp=1", ev1); end
    clr_v[1] = 1'b1; pre_v[1] = 1'b1; en_v[1] = 1'b0; d_v[1] = 1'b1;
    tick();
    n_cmp++; if (eq1 !== 1'b1) begin n_bad++; $display("FAIL al_exp_q2 got=%0d exp=1", eq1); end
    n_cmp++; if (mm1 !== 1'b0) begin n_bad++; $display("FAIL al_mm2 got=%0d exp=0", mm1); end
    tick();
    n_cmp++; if (mm1 !== 1'b0) begin n_bad++; $display("FAIL al_mm3 got=%0d exp=0", mm1); end
    tick();
    n_cmp++; if (mm1 !== 1'b1) begin n_bad++; $display("FAIL al_mm4 got=%0d exp=1", mm1); end
    n_cmp++; if (fl1 !== 1'b1) begin n_bad++; $display("FAIL al_fail got=%0d exp=1", fl1); end
    n_cmp++; if (ec1 !== 8'd1) begin n_bad++; $display("FAIL al_cnt4 got=%0d exp=1", ec1); end
    n_cmp++; if (st1 !== 2'd2) begin n_bad++; $display("FAIL al_state4 got=%0d exp=2", st1); end
    tick();
    n_cmp++; if (mm1 !== 1'b1) begin n_bad++; $display("FAIL al_mm5 got=%0d exp=1", mm1); end
    n_cmp++; if (ec1 !== 8'd2) begin n_bad++; $display("FAIL al_cnt5 got=%0d exp=2", ec1); end
  endtask

  task automatic test_saturate();
    int         pulses;
    logic [1:0] exp_cnt;
    pulses = 0;
    en_v[2] = 1'b1; d_v[2] = 1'b1; q_v[2] = 1'b0;
    tick();
    n_cmp++; if (st2 !== 2'd1) begin n_bad++; $display("FAIL sat_state1 got=%0d exp=1", st2); end
    n_cmp++; if (eq2 !== 1'b1) begin n_bad++; $display("FAIL sat_exp_q got=%0d exp=1", eq2); end
    n_cmp++; if (mm2 !== 1'b0) begin n_bad++; $display("FAIL sat_mm1 got=%0d exp=0", mm2); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_cnt = (k < 3) ? 2'(k) : 2'd3;
      if (mm2 === 1'b1) pulses++;
      n_cmp++; if (ec2 !== exp_cnt) begin n_bad++; $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, ec2, exp_cnt); end
    end
    n_cmp++; if (pulses !== 6) begin n_bad++; $display("FAIL sat_pulses got=%0d exp=6", pulses); end
    n_cmp++; if (fl2 !== 1'b1) begin n_bad++; $display("FAIL sat_fail got=%0d exp=1", fl2); end
    n_cmp++; if (st2 !== 2'd2) begin n_bad++; $display("FAIL sat_state got=%0d exp=2", st2); end
    q_v[2] = 1'b1;
    tick();
    n_cmp++; if (mm2 !== 1'b0) begin n_bad++; $display("FAIL sat_match_mm got=%0d exp=0", mm2); end
    n_cmp++; if (ec2 !== 2'd3) begin n_bad++; $display("FAIL sat_match_cnt got=%0d exp=3", ec2); end
  endtask

  task automatic test_data_change();
    d_v[2] = 1'b0; q_v[2] = 1'b0;
    tick();
    n_cmp++; if (mm2 !== 1'b0) begin n_bad++; $display("FAIL dchg_mm got=%0d exp=0", mm2); end
    n_cmp++; if (eq2 !== 1'b0) begin n_bad++; $display("FAIL dchg_exp_q got=%0d exp=0", eq2); end
    n_cmp++; if (st2 !== 2'd1) begin n_bad++; $display("FAIL dchg_state got=%0d exp=1", st2); end
    tick();
    n_cmp++; if (mm2 !== 1'b0) begin n_bad++; $display("FAIL dstable_mm got=%0d exp=0", mm2); end
    n_cmp++; if (st2 !== 2'd2) begin n_bad++; $display("FAIL dstable_state got=%0d exp=2", st2); end
  endtask

  initial begin
    test_reset();
    test_clr_settle();
    test_priority();
    test_mismatch_err_clr();
    test_reset_mid_settle();
    test_active_low();
    test_saturate();
    test_data_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lat_monitor.md
LAT_MONITOR -- requirements
Module: lat_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter ACTIVE_LOW, default 0: 1 = en/pre/clr inputs are active-low (nlatsr style); 0 = active-high (latsr style).
REQ-003 Parameter SETTLE, default 1, range 0..15: grace cycles after any control/data change before comparison.
REQ-004 Parameter ERR_W, default 8: error counter width.
REQ-005 Ports: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 en  in  1  latch enable under observation.
REQ-008 pre  in  1  latch preset under observation.
REQ-009 clr  in  1  latch clear under observation.
REQ-010 d  in  1  latch data under observation.
REQ-011 q  in  1  observed latch output.
REQ-012 err_clr  in  1  synchronous clear of fail and err_cnt.
REQ-013 exp_q  out  1  model expected latch value.
REQ-014 exp_valid  out  1  model value defined.
REQ-015 mismatch  out  1  one-cycle pulse per detected mismatch.
REQ-016 fail  out  1  sticky mismatch flag.
REQ-017 err_cnt  out  ERR_W  saturating mismatch count.
REQ-018 state  out  2  FSM state: 0 UNK, 1 SETTLE, 2 CHECK.

Function
REQ-019 Normalization: c = clr^ACTIVE_LOW, p = pre^ACTIVE_LOW, e = en^ACTIVE_LOW; all logic below SHALL use c/p/e.
REQ-020 Model priority each edge: c -> exp_q=0; else p -> exp_q=1; else e -> exp_q=d; else hold; any of c/p/e asserted -> exp_valid=1.
REQ-021 Change event at an edge: {c,p,e} differs from the previous edge's sample, or e=1 with c=p=0 and d differs from the previous sample.
REQ-022 Settle counter: a change event SHALL load SETTLE; otherwise the counter decrements, saturating at 0.
REQ-023 Comparison at edge N SHALL occur only if exp_valid=1, counter=0 and no change event at edge N (register values before edge N); q at N is compared against exp_q registered at N-1.
REQ-024 On a failed comparison at edge N: mismatch=1 for exactly the cycle after N, fail=1, err_cnt+1 saturating at 2^ERR_W-1.
REQ-025 FSM: UNK->SETTLE on the first defining event; SETTLE->CHECK when counter=0 and no change event; CHECK->SETTLE on a change event; no other exits except reset.
REQ-026 In UNK, no comparison SHALL occur; mismatch SHALL remain 0.
REQ-027 err_clr with a simultaneous mismatch: clear first, then count; result is err_cnt=1, fail=1.
REQ-028 With SETTLE=0, a change at N-1 followed by a stable edge N SHALL permit comparison at N.
REQ-029 Counter saturated: further mismatches SHALL pulse mismatch but leave err_cnt unchanged.

Reset
REQ-030 rst=1 at an edge SHALL set exp_q=0, exp_valid=0, mismatch=0, fail=0, err_cnt=0, counter=0, state=UNK, previous-sample registers=0; this overrides err_clr and in-flight comparisons.
REQ-031 Reset asserted mid-SETTLE or mid-CHECK SHALL discard the pending comparison; no mismatch pulse follows.

Verification
REQ-032 ACTIVE_LOW=0, SETTLE=1: clr=1 for 1 cycle, then clr=0, q=0 held 4 cycles -> exp_q=0, state UNK->SETTLE->CHECK, err_cnt=0.
REQ-033 ACTIVE_LOW=0: pre=1, en=1, d=0 simultaneously, q=1 -> exp_q=1 (pre beats en), no mismatch.
REQ-034 ACTIVE_LOW=1: clr=0 one cycle, then clr=pre=1, en=0, d=1, q=0 held -> exp_q=1, one mismatch pulse per compared cycle, fail=1.
REQ-035 ERR_W=2, forced q!=exp_q for 6 compared cycles -> err_cnt stops at 3, mismatch pulses 6 times, fail=1.
REQ-036 Mismatch and err_clr in the same cycle -> err_cnt=1, fail=1; rst mid-SETTLE -> all outputs 0, state=UNK.
